cart_loader: RTL and testbench
==============================

CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-002 reset_l  in  1  reset, asynchronous, active-low.
REQ-003 ioctl_download  in  1  HPS download window active.
REQ-004 ioctl_wr  in  1  one-cycle strobe: ioctl_dout valid at ioctl_addr.
REQ-005 ioctl_index  in  8  target image: 0 = BIOS, 1 = cart, other = discard.
REQ-006 ioctl_addr  in  25  byte address of the download write.
REQ-007 ioctl_dout  in  8  download data byte.
REQ-008 cpu_cart_addr  in  13  cart read address from the console core.
REQ-009 cpu_bios_addr  in  13  BIOS read address from the console core.
REQ-010 cart_addr  out  13  cart RAM address.
REQ-011 bios_addr  out  13  BIOS RAM address.
REQ-012 ram_data  out  8  write data to both RAMs.
REQ-013 cart_we  out  1  cart RAM write enable.
REQ-014 bios_we  out  1  BIOS RAM write enable.
REQ-015 hold_reset  out  1  active-high core reset request.
REQ-016 cart_size  out  14  highest cart byte address written plus 1, range 0..8192.
REQ-017 overflow  out  1  sticky: the last download wrote at an address of 8192 or higher.
REQ-018 busy  out  1  high in LOAD and PAD.

Function
REQ-019 States: SETTLE, RUN, LOAD, PAD. Registered outputs unless stated otherwise.
REQ-020 Download start is ioctl_download sampled 0->1 via a registered previous value; download end is 1->0.
REQ-021 Download start from any state -> LOAD next cycle.
  - Latch ioctl_index.
  - Clear the byte count and overflow.
  - Set hold_reset=1.
  - A start during PAD or SETTLE aborts that state.
REQ-022 LOAD, ioctl_wr=1 with ioctl_addr < 8192, latched index 0 or 1:
  - Write ioctl_dout to the selected RAM at ioctl_addr[12:0] in the same cycle (combinational we, address, data).
  - Count becomes max(count, ioctl_addr+1).
REQ-023 LOAD, ioctl_wr=1 with ioctl_addr >= 8192: no write; overflow=1 next cycle.
REQ-024 LOAD, ioctl_wr=1 with another index: no write, count unchanged.
REQ-025 Download end, latched index 1 and count < 8192 -> PAD with pointer = count; otherwise -> SETTLE.
REQ-026 Download end and ioctl_wr in the same cycle: the write is performed before leaving LOAD.
REQ-027 PAD:
  - One write of 8'hFF to the cart RAM per cycle at the pointer; pointer +1.
  - After the write at 8191 -> SETTLE.
  - Count 0 pads all 8192 bytes.
  - Count N takes 8192-N cycles.
REQ-028 SETTLE:
  - Hold hold_reset=1 for exactly 16 cycles with a 4-bit counter, then -> RUN with hold_reset=0.
REQ-029 RUN: cart_addr=cpu_cart_addr, bios_addr=cpu_bios_addr, combinationally; both write enables 0.
REQ-030 Outside RUN, cart_addr and bios_addr carry the loader address; the CPU addresses are ignored.
REQ-031 cart_size updates only at download end, for index 1; it holds otherwise.
REQ-032 At most one write enable is high in any cycle.

Reset
REQ-033 reset_l=0 asynchronously forces:
  - state SETTLE, counter 0, hold_reset=1;
  - cart_we=0, bios_we=0, busy=0, overflow=0, cart_size=0;
  - latched index 0, previous-download register 0.
REQ-034 After reset_l deasserts, SETTLE runs 16 cycles, then RUN.
REQ-035 Reset during LOAD or PAD abandons the operation; RAM contents already written are kept.
REQ-036 If ioctl_download is already 1 when reset releases, the 0->1 edge is detected and LOAD is entered.

Verification
REQ-037 Reset release, no download -> hold_reset=1 for 16 cycles, then 0; cart_addr tracks cpu_cart_addr=13'h0ABC.
REQ-038 Index 1, writes at 0..4095 of data addr[7:0], then end:
  - cart_size=4096;
  - 4096 PAD writes of FF at 4096..8191;
  - then 16 SETTLE cycles; busy low from SETTLE onward.
REQ-039 Index 0, 8192 bytes -> bios_we pulses 8192 times, cart_we never high, no PAD, cart_size unchanged, overflow=0.
REQ-040 Index 1 with a write at 0x2000 -> no write, overflow=1, cart_size=8192 if 0..8191 were also written.
REQ-041 New download start at PAD pointer 6000 -> LOAD next cycle, PAD writes stop, count cleared, hold_reset stays 1.
REQ-042 Index 5 download of 100 bytes -> no write enables, SETTLE directly at end, cart_size unchanged.

Source files
------------

// File: rtl/cart_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : cart_loader_if
// Purpose  : HPS download bus into the cartridge/BIOS loader. The HPS side
//            drives every signal; the loader only observes them.
// Signals  : ioctl_download  download window active
//            ioctl_wr        one-cycle write strobe
//            ioctl_index     target image (0 = BIOS, 1 = cart, other = discard)
//            ioctl_addr      byte address of the write
//            ioctl_dout      data byte of the write
// Revision : 1.0  initial release
// ============================================================================
interface cart_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout
  );

  modport slave (
    input ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout
  );
endinterface
`default_nettype wire

// File: rtl/cart_loader.sv
`default_nettype none
// ============================================================================
// Module   : cart_loader
// Purpose  : Loads BIOS / cartridge images from the HPS download bus into two
//            8 KiB RAMs, pads short cartridges with 8'hFF, and holds the
//            console core in reset while loading plus 16 settle cycles.
// Ports    : clk_sys        system clock
//            reset_l        asynchronous active-low reset
//            ioctl          download bus (slave modport)
//            cpu_cart_addr  cart read address from the core
//            cpu_bios_addr  BIOS read address from the core
//            cart_addr      cart RAM address   (combinational)
//            bios_addr      BIOS RAM address   (combinational)
//            ram_data       write data to both RAMs (combinational)
//            cart_we        cart RAM write enable (combinational)
//            bios_we        BIOS RAM write enable (combinational)
//            hold_reset     core reset request
//            cart_size      highest cart byte written + 1 (0..8192)
//            overflow       last download wrote at address >= 8192
//            busy           high while loading or padding
// Revision : 1.0  initial release
// ============================================================================
module cart_loader (
  input  logic         clk_sys,
  input  logic         reset_l,
  cart_loader_if.slave ioctl,
  input  logic [12:0]  cpu_cart_addr,
  input  logic [12:0]  cpu_bios_addr,
  output logic [12:0]  cart_addr,
  output logic [12:0]  bios_addr,
  output logic [7:0]   ram_data,
  output logic         cart_we,
  output logic         bios_we,
  output logic         hold_reset,
  output logic [13:0]  cart_size,
  output logic         overflow,
  output logic         busy
);

  localparam logic [7:0]  IDX_BIOS = 8'd0;
  localparam logic [7:0]  IDX_CART = 8'd1;
  localparam logic [7:0]  PAD_BYTE = 8'hFF;
  localparam logic [12:0] LAST_ADDR = 13'h1FFF;

  typedef enum logic [1:0] {SETTLE, RUN, LOAD, PAD} state_t;

  state_t      state, state_n;
  logic        prev_dl;
  logic [7:0]  index;
  logic [13:0] count;
  logic [12:0] pad_ptr, pad_ptr_n;
  logic [3:0]  settle_cnt, settle_cnt_n;

  logic        dl_start, dl_end;
  logic        in_range, index_ok, load_wr;
  logic [13:0] addr_plus1, count_upd;
  logic [12:0] loader_addr;

  assign dl_start   = ioctl.ioctl_download & ~prev_dl;
  assign dl_end     = ~ioctl.ioctl_download & prev_dl;
  assign in_range   = (ioctl.ioctl_addr[24:13] == 12'd0);
  assign index_ok   = (index == IDX_BIOS) || (index == IDX_CART);
  assign load_wr    = (state == LOAD) && ioctl.ioctl_wr && in_range && index_ok;
  assign addr_plus1 = {1'b0, ioctl.ioctl_addr[12:0]} + 14'd1;
  // Count including a write in this very cycle, so a write coinciding with
  // download end is reflected in cart_size and the pad start pointer.
  assign count_upd  = (load_wr && (addr_plus1 > count)) ? addr_plus1 : count;

  // Next-state logic
  always_comb begin
    state_n      = state;
    pad_ptr_n    = pad_ptr;
    settle_cnt_n = settle_cnt;
    case (state)
      SETTLE: begin
        settle_cnt_n = settle_cnt + 4'd1;
        if (settle_cnt == 4'd15) state_n = RUN;
      end
      RUN: ;
      LOAD: begin
        if (dl_end) begin
          settle_cnt_n = 4'd0;
          // count_upd[13] set means all 8192 bytes are present: nothing to pad
          if ((index == IDX_CART) && !count_upd[13]) begin
            state_n   = PAD;
            pad_ptr_n = count_upd[12:0];
          end else begin
            state_n = SETTLE;
          end
        end
      end
      PAD: begin
        pad_ptr_n = pad_ptr + 13'd1;
        if (pad_ptr == LAST_ADDR) begin
          state_n      = SETTLE;
          settle_cnt_n = 4'd0;
        end
      end
      default: state_n = SETTLE;
    endcase
    // A new download pre-empts whatever the loader is doing
    if (dl_start) state_n = LOAD;
  end

  // RAM-side outputs are combinational so writes land in the strobe cycle
  always_comb begin
    loader_addr = (state == PAD) ? pad_ptr : ioctl.ioctl_addr[12:0];
    cart_we     = (load_wr && (index == IDX_CART)) || (state == PAD);
    bios_we     = load_wr && (index == IDX_BIOS);
    ram_data    = (state == PAD) ? PAD_BYTE : ioctl.ioctl_dout;
    cart_addr   = (state == RUN) ? cpu_cart_addr : loader_addr;
    bios_addr   = (state == RUN) ? cpu_bios_addr : loader_addr;
  end

  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      state      <= SETTLE;
      prev_dl    <= 1'b0;
      index      <= 8'd0;
      count      <= 14'd0;
      pad_ptr    <= 13'd0;
      settle_cnt <= 4'd0;
      hold_reset <= 1'b1;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      cart_size  <= 14'd0;
    end else begin
      state      <= state_n;
      prev_dl    <= ioctl.ioctl_download;
      pad_ptr    <= pad_ptr_n;
      settle_cnt <= settle_cnt_n;
      hold_reset <= (state_n != RUN);
      busy       <= (state_n == LOAD) || (state_n == PAD);
      if (dl_start) begin
        index    <= ioctl.ioctl_index;
        count    <= 14'd0;
        overflow <= 1'b0;
      end else if (state == LOAD) begin
        count <= count_upd;
        if (ioctl.ioctl_wr && !in_range) overflow <= 1'b1;
        if (dl_end && (index == IDX_CART)) cart_size <= count_upd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cart_loader
// Purpose  : Directed self-checking bench for cart_loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_cart_loader;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [12:0] cpu_cart_addr, cpu_bios_addr;
  logic [12:0] cart_addr, bios_addr;
  logic [7:0]  ram_data;
  logic        cart_we, bios_we, hold_reset, overflow, busy;
  logic [13:0] cart_size;

  int checks = 0;
  int passes = 0;

  cart_loader_if bus();

  cart_loader dut (
    .clk_sys       (clk),
    .reset_l       (reset_l),
    .ioctl         (bus),
    .cpu_cart_addr (cpu_cart_addr),
    .cpu_bios_addr (cpu_bios_addr),
    .cart_addr     (cart_addr),
    .bios_addr     (bios_addr),
    .ram_data      (ram_data),
    .cart_we       (cart_we),
    .bios_we       (bios_we),
    .hold_reset    (hold_reset),
    .cart_size     (cart_size),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Stimulus helpers
  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr       = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic end_dl();
    @(negedge clk);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_run(input int limit, output bit reached);
    reached = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (hold_reset === 1'b0) begin
        reached = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int highs;
    reset_l = 1'b0;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_index = 8'd0;
    bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'd0;
    cpu_cart_addr = 13'h0ABC; cpu_bios_addr = 13'h1555;
    #23;
    checks++; if (hold_reset !== 1'b1) $display("FAIL reset_hold got %b want 1", hold_reset); else passes++;
    checks++; if ({busy, cart_we, bios_we, overflow} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {busy, cart_we, bios_we, overflow}); else passes++;
    checks++; if (cart_size !== 14'd0) $display("FAIL reset_size got %0d want 0", cart_size); else passes++;
    @(negedge clk); reset_l = 1'b1;
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (hold_reset === 1'b1) highs++;
    end
    checks++; if (highs != 15) $display("FAIL settle_high got %0d want 15", highs); else passes++;
    @(posedge clk); #1;
    checks++; if (hold_reset !== 1'b0) $display("FAIL settle_release got %b want 0", hold_reset); else passes++;
    checks++; if (cart_addr !== 13'h0ABC) $display("FAIL run_cart_addr got %h want 0abc", cart_addr); else passes++;
    checks++; if (bios_addr !== 13'h1555) $display("FAIL run_bios_addr got %h want 1555", bios_addr); else passes++;
    cpu_cart_addr = 13'h1234; #1;
    checks++; if (cart_addr !== 13'h1234) $display("FAIL run_track got %h want 1234", cart_addr); else passes++;
  endtask

  task automatic test_cart_load();
    int good, pads, bad, highs, expa;
    bit bios_seen;
    start_dl(8'd1);
    checks++; if ({busy, hold_reset} !== 2'b11) $display("FAIL cart_start got %b want 11", {busy, hold_reset}); else passes++;
    good = 0; bios_seen = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      @(negedge clk);
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = 8'(a); #1;
      if (cart_we === 1'b1 && bios_we === 1'b0 && cart_addr === 13'(a) && ram_data === 8'(a)) good++;
    end
    end_dl();
    checks++; if (good != 4096) $display("FAIL cart_writes got %0d want 4096", good); else passes++;
    checks++; if (cart_size !== 14'd4096) $display("FAIL cart_size got %0d want 4096", cart_size); else passes++;
    pads = 0; bad = 0; expa = 4096;
    while (cart_we === 1'b1 && pads < 9000) begin
      if (cart_addr !== 13'(expa) || ram_data !== 8'hFF) bad++;
      if (bios_we !== 1'b0) bios_seen = 1'b1;
      pads++; expa++;
      @(posedge clk); #1;
    end
    checks++; if (pads != 4096) $display("FAIL pad_count got %0d want 4096", pads); else passes++;
    checks++; if (bad != 0) $display("FAIL pad_data got %0d bad want 0", bad); else passes++;
    checks++; if (bios_seen) $display("FAIL pad_bios_we got 1 want 0"); else passes++;
    checks++; if ({busy, hold_reset} !== 2'b01) $display("FAIL pad_settle got %b want 01", {busy, hold_reset}); else passes++;
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (hold_reset === 1'b1 && busy === 1'b0) highs++;
    end
    checks++; if (highs != 15) $display("FAIL cart_settle got %0d want 15", highs); else passes++;
    @(posedge clk); #1;
    checks++; if (hold_reset !== 1'b0) $display("FAIL cart_run got %b want 0", hold_reset); else passes++;
  endtask

  task automatic test_bios_load();
    int pulses;
    bit cart_seen, reached;
    start_dl(8'd0);
    pulses = 0; cart_seen = 1'b0;
    for (int a = 0; a < 8192; a++) begin
      @(negedge clk);
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = 8'(a ^ 8'h3C); #1;
      if (bios_we === 1'b1 && bios_addr === 13'(a) && ram_data === 8'(a ^ 8'h3C)) pulses++;
      if (cart_we !== 1'b0) cart_seen = 1'b1;
    end
    end_dl();
    checks++; if (pulses != 8192) $display("FAIL bios_pulses got %0d want 8192", pulses); else passes++;
    checks++; if (cart_seen) $display("FAIL bios_cart_we got 1 want 0"); else passes++;
    checks++; if ({busy, cart_we} !== 2'b00) $display("FAIL bios_no_pad got %b want 00", {busy, cart_we}); else passes++;
    checks++; if (cart_size !== 14'd4096) $display("FAIL bios_size got %0d want 4096", cart_size); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL bios_ovf got %b want 0", overflow); else passes++;
    wait_run(40, reached);
    checks++; if (!reached) $display("FAIL bios_run got timeout want run"); else passes++;
  endtask

  task automatic test_overflow();
    bit reached;
    start_dl(8'd1);
    for (int a = 0; a < 8192; a++) begin
      @(negedge clk);
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = 8'(a);
    end
    @(negedge clk);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h2000; bus.ioctl_dout = 8'h5A; #1;
    checks++; if ({cart_we, bios_we} !== 2'b00) $display("FAIL ovf_write got %b want 00", {cart_we, bios_we}); else passes++;
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passes++;
    end_dl();
    checks++; if (cart_size !== 14'd8192) $display("FAIL ovf_size got %0d want 8192", cart_size); else passes++;
    checks++; if ({busy, overflow} !== 2'b01) $display("FAIL ovf_end got %b want 01", {busy, overflow}); else passes++;
    wait_run(40, reached);
    checks++; if (!reached) $display("FAIL ovf_run got timeout want run"); else passes++;
  endtask

  task automatic test_pad_abort();
    bit reached;
    start_dl(8'd1);
    checks++; if (overflow !== 1'b0) $display("FAIL abort_ovf_clr got %b want 0", overflow); else passes++;
    for (int a = 0; a < 6000; a++) begin
      @(negedge clk);
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = 8'(a);
      if (a == 5999) bus.ioctl_download = 1'b0;
    end
    @(posedge clk); #1;
    bus.ioctl_wr = 1'b0;
    checks++; if (cart_size !== 14'd6000) $display("FAIL abort_size got %0d want 6000", cart_size); else passes++;
    checks++; if ({cart_we, cart_addr} !== {1'b1, 13'd6000})
      $display("FAIL abort_pad_ptr got %b/%0d want 1/6000", cart_we, cart_addr); else passes++;
    start_dl(8'd1);
    checks++; if ({busy, hold_reset, cart_we} !== 3'b110)
      $display("FAIL abort_load got %b want 110", {busy, hold_reset, cart_we}); else passes++;
    @(negedge clk);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd9; bus.ioctl_dout = 8'h77; #1;
    checks++; if ({cart_we, cart_addr, ram_data} !== {1'b1, 13'd9, 8'h77})
      $display("FAIL abort_write got %b/%0d/%h want 1/9/77", cart_we, cart_addr, ram_data); else passes++;
    end_dl();
    checks++; if (cart_size !== 14'd10) $display("FAIL abort_count got %0d want 10", cart_size); else passes++;
    checks++; if (cart_addr !== 13'd10) $display("FAIL abort_pad2 got %0d want 10", cart_addr); else passes++;
    wait_run(9000, reached);
    checks++; if (!reached) $display("FAIL abort_run got timeout want run"); else passes++;
  endtask

  task automatic test_discard();
    bit we_seen, reached;
    start_dl(8'd5);
    we_seen = 1'b0;
    for (int a = 0; a < 100; a++) begin
      @(negedge clk);
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = 8'hA5; #1;
      if (cart_we !== 1'b0 || bios_we !== 1'b0) we_seen = 1'b1;
    end
    end_dl();
    checks++; if (we_seen) $display("FAIL discard_we got 1 want 0"); else passes++;
    checks++; if ({busy, hold_reset, cart_we} !== 3'b010)
      $display("FAIL discard_settle got %b want 010", {busy, hold_reset, cart_we}); else passes++;
    checks++; if (cart_size !== 14'd10) $display("FAIL discard_size got %0d want 10", cart_size); else passes++;
    wait_run(40, reached);
    checks++; if (!reached) $display("FAIL discard_run got timeout want run"); else passes++;
  endtask

  task automatic test_reset_in_load();
    int pads;
    start_dl(8'd1);
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = 8'(a);
    end
    @(negedge clk);
    bus.ioctl_wr = 1'b0; reset_l = 1'b0; #1;
    checks++; if ({busy, hold_reset, cart_we} !== 3'b010)
      $display("FAIL rst_abort got %b want 010", {busy, hold_reset, cart_we}); else passes++;
    checks++; if (cart_size !== 14'd0) $display("FAIL rst_size got %0d want 0", cart_size); else passes++;
    @(negedge clk); reset_l = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) $display("FAIL rst_dl_held got %b want 1", busy); else passes++;
    end_dl();
    checks++; if ({cart_we, cart_addr} !== {1'b1, 13'd0})
      $display("FAIL pad_full_start got %b/%0d want 1/0", cart_we, cart_addr); else passes++;
    pads = 0;
    while (cart_we === 1'b1 && pads < 9000) begin
      pads++;
      @(posedge clk); #1;
    end
    checks++; if (pads != 8192) $display("FAIL pad_full got %0d want 8192", pads); else passes++;
  endtask

  initial begin
    test_reset();
    test_cart_load();
    test_bios_load();
    test_overflow();
    test_pad_abort();
    test_discard();
    test_reset_in_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
